// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, branch flush, memory-wait freeze with watchdog.
// Optional stall-cycle statistics counter enabled by defining STALL_STATS_EN.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             branch_taken,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             timeout_nxt;
    logic             mem_op, lu;
    logic [4:0]       hold_c;   // {pc, ifid, idex, exmem, memwb}
    logic             req_c, bubble_c, flush_c;

    assign mem_op = exmem_memread | exmem_memwrite;
    assign lu     = idex_memread && (idex_rt != 5'd0) &&
                    (idex_rt == ifid_rs || idex_rt == ifid_rt);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = mem_timeout;
        hold_c       = 5'b0;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        req_c        = mem_op && (state != ERROR);
        case (state)
            RUN, MEM_WAIT: begin
                if (req_c && !dmem_ready) begin
                    hold_c = 5'b11111;
                    if (state == RUN) begin
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = CNT_W'(1);
                    end else begin
                        if (wait_cnt != '1)
                            wait_cnt_nxt = wait_cnt + CNT_W'(1);
                        if (TIMEOUT_CYCLES != 0 && wait_cnt == TMO) begin
                            state_nxt   = ERROR;
                            timeout_nxt = 1'b1;
                        end
                    end
                end else begin
                    // Pipe advances; a taken branch blocked by load-use gets flushed next cycle.
                    if (lu) begin
                        hold_c   = 5'b11000;
                        bubble_c = 1'b1;
                    end else begin
                        flush_c = branch_taken;
                    end
                    if (state == MEM_WAIT) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end
                end
            end
            ERROR:   hold_c = 5'b11111;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold} = hold_c & {5{rst_n}};
    assign dmem_req    = req_c & rst_n;
    assign idex_bubble = bubble_c & rst_n;
    assign ifid_flush  = flush_c & rst_n;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (pc_hold && stall_q != '1)
            stall_q <= stall_q + CNT_W'(1);
    end
    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: single-cycle vector table plus multi-cycle stall/timeout/reset sequences.
module tb_pipeline_stall_ctrl;
    localparam int CNT_W = 32;
`ifdef STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic idex_memread, branch_taken, exmem_memread, exmem_memwrite, dmem_ready;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic dmem_req, pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold;
    logic idex_bubble, ifid_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken), .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
        .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    // {dmem_req, pc, ifid, idex, exmem, memwb, bubble, flush}
    logic [7:0] obs;
    assign obs = {dmem_req, pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold, idex_bubble, ifid_flush};

    typedef struct {
        string      name;
        logic       memread;
        logic [4:0] rt_x, rs, rt;
        logic       br, exr, exw, rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        branch_taken = 0; exmem_memread = 0; exmem_memwrite = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    initial begin
        vecs[0]  = '{"idle",          0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 8'h00};
        vecs[1]  = '{"lu_rs",         1, 5'd8, 5'd8, 5'd0,  0, 0, 0, 0, 8'h62};
        vecs[2]  = '{"lu_rt",         1, 5'd8, 5'd3, 5'd8,  0, 0, 0, 0, 8'h62};
        vecs[3]  = '{"lu_r0",         1, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 8'h00};
        vecs[4]  = '{"no_memread",    0, 5'd8, 5'd8, 5'd8,  0, 0, 0, 0, 8'h00};
        vecs[5]  = '{"branch",        0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 0, 8'h01};
        vecs[6]  = '{"branch_lu",     1, 5'd9, 5'd9, 5'd1,  1, 0, 0, 0, 8'h62};
        vecs[7]  = '{"zw_read",       0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 1, 8'h80};
        vecs[8]  = '{"zw_write_br",   0, 5'd0, 5'd0, 5'd0,  1, 0, 1, 1, 8'h81};
        vecs[9]  = '{"zw_read_lu",    1, 5'd8, 5'd0, 5'd8,  0, 1, 0, 1, 8'hE2};
        vecs[10] = '{"lu_nomatch",    1, 5'd8, 5'd9, 5'd10, 0, 0, 0, 0, 8'h00};

        // Reset: outputs low even with hazard-causing inputs.
        clear_in();
        rst_n = 0;
        exmem_memread = 1; idex_memread = 1; idex_rt = 8; ifid_rs = 8; branch_taken = 1;
        #3;
        chk("reset_outs", 32'(obs), 32'h00);
        chk("reset_timeout", 32'(mem_timeout), 32'h0);
        chk("reset_stall_cnt", stall_cnt, 32'h0);
        tick();
        do_reset();

        // Single-cycle vectors, all staying in RUN.
        for (int i = 0; i < 11; i++) begin
            idex_memread = vecs[i].memread; idex_rt = vecs[i].rt_x;
            ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; branch_taken = vecs[i].br;
            exmem_memread = vecs[i].exr; exmem_memwrite = vecs[i].exw; dmem_ready = vecs[i].rdy;
            #2;
            chk({"vec_", vecs[i].name}, 32'(obs), 32'(vecs[i].exp));
            tick();
        end

        // Load-use: one bubble, then ID/EX holds the bubble and the hazard is gone.
        clear_in();
        idex_memread = 1; idex_rt = 8; ifid_rs = 8;
        #2 chk("lu_cycle1", 32'(obs), 32'h62);
        tick();
        idex_memread = 0;
        #2 chk("lu_cycle2", 32'(obs), 32'h00);
        tick();

        // Branch blocked by load-use is flushed the following cycle.
        idex_memread = 1; idex_rt = 8; ifid_rt = 8; ifid_rs = 0; branch_taken = 1;
        #2 chk("br_lu_cycle1", 32'(obs), 32'h62);
        tick();
        idex_memread = 0;
        #2 chk("br_lu_cycle2", 32'(obs), 32'h01);
        tick();

        // 3-cycle memory wait, release with a branch, then one load-use bubble.
        do_reset();
        exmem_memread = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("memwait_%0d", i), 32'(obs), 32'hFC);
            tick();
        end
        dmem_ready = 1; branch_taken = 1;
        #2 chk("memwait_release", 32'(obs), 32'h81);
        tick();
        clear_in();
        idex_memread = 1; idex_rt = 8; ifid_rs = 8;
        #2 chk("memwait_then_lu", 32'(obs), 32'h62);
        tick();
        clear_in();
        #2 chk("stall_cnt_4", stall_cnt, STATS ? 32'd4 : 32'd0);

        // Watchdog: stuck memory enters ERROR after 4 MEM_WAIT cycles.
        do_reset();
        exmem_memread = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (i == 4) begin
                chk("tmo_last_wait_outs", 32'(obs), 32'hFC);
                chk("tmo_last_wait_flag", 32'(mem_timeout), 32'h0);
            end
            tick();
        end
        #2;
        chk("error_outs", 32'(obs), 32'h7C);
        chk("error_flag", 32'(mem_timeout), 32'h1);
        tick();
        dmem_ready = 1; exmem_memread = 0; idex_memread = 1; idex_rt = 8; ifid_rs = 8;
        #2;
        chk("error_sticky_outs", 32'(obs), 32'h7C);
        chk("error_sticky_flag", 32'(mem_timeout), 32'h1);
        chk("error_stall_cnt", stall_cnt, STATS ? 32'd6 : 32'd0);
        rst_n = 0;
        #1;
        chk("error_reset_flag", 32'(mem_timeout), 32'h0);
        chk("error_reset_outs", 32'(obs), 32'h00);
        tick();

        // Reset in the middle of a memory wait.
        do_reset();
        exmem_memread = 1; dmem_ready = 0;
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("midwait_reset_req", 32'(dmem_req), 32'h0);
        chk("midwait_reset_stall_cnt", stall_cnt, 32'h0);
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) tick();
        #2;
        chk("midwait_restart_outs", 32'(obs), 32'hFC);
        chk("midwait_restart_flag", 32'(mem_timeout), 32'h0);
        tick();
        #2;
        chk("midwait_restart_error", 32'(mem_timeout), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
